keypad_scan: RTL and testbench

- Input-side counterpart of the multiplexed 4-digit seven-segment display driver.
- Scans a 4x4 matrix keypad by driving one active-low column at a time and sampling four active-low rows.
- Debounces the result and emits a one-cycle key event plus a held level.
- Feeds the countdown control logic, for example for digit entry and start/stop keys.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_scan_if.sv | 26 ++
 rtl/keypad_debounce.sv | 86 ++++++++
 rtl/two_four_decoder.sv | 13 +
 rtl/keypad_scan.sv | 104 ++++++++++
 tb/tb_keypad_scan.sv | 221 ++++++++++++++++++++++
 6 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: scan-candidate encoding,
// debounce FSM states and key-code field widths.
package keypad_pkg;

  localparam int ROW_W  = 2;
  localparam int COL_W  = 2;
  localparam int CODE_W = ROW_W + COL_W;
  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;

  // What one full scan of the matrix saw.
  typedef enum logic [1:0] {
    CAND_NONE  = 2'd0,
    CAND_MULTI = 2'd1,
    CAND_KEY   = 2'd2
  } cand_kind_e;

  // The code field is zero unless kind is CAND_KEY, so plain equality
  // compares candidates correctly.
  typedef struct packed {
    cand_kind_e          kind;
    logic [CODE_W-1:0]   code;
  } cand_t;

  localparam cand_t CAND_RESET = '{kind: CAND_NONE, code: '0};

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } key_state_e;

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pins plus the decoded key outputs seen by the countdown control.
interface keypad_scan_if
  import keypad_pkg::*;
  ();
  logic [N_ROWS-1:0] row_n;
  logic [N_COLS-1:0] col_n;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_down;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keypad_debounce.sv
// Debounce of per-scan candidates and press/release FSM. A candidate must
// repeat for DEBOUNCE_SCANS consecutive scans before it is acted upon.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eos,
  input  cand_t             cand,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_down
);

  localparam int              SC_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(DEBOUNCE_SCANS);
  localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);

  key_state_e        state_q, state_d;
  logic [SC_W-1:0]   stable_q, stable_d;
  cand_t             prev_q, prev_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              down_q, down_d;

  function automatic logic [SC_W-1:0] sat_stable(input logic [SC_W-1:0] v);
    return (v >= SC_MAX) ? SC_MAX : v + SC_ONE;
  endfunction

  // Run-length compare of candidates and press/release decisions at end of scan.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    prev_d   = prev_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    down_d   = down_q;
    if (eos) begin
      stable_d = (cand == prev_q) ? sat_stable(stable_q) : SC_ONE;
      prev_d   = cand;
      case (state_q)
        ST_IDLE: begin
          if (cand.kind == CAND_KEY && stable_d == SC_MAX) begin
            state_d = ST_PRESSED;
            code_d  = cand.code;
            valid_d = 1'b1;
            down_d  = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (cand.kind == CAND_NONE && stable_d == SC_MAX) begin
            state_d = ST_IDLE;
            down_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      stable_q <= '0;
      prev_q   <= CAND_RESET;
      code_q   <= '0;
      valid_q  <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      down_q   <= down_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule

// File: rtl/two_four_decoder.sv
// 2-to-4 decoder with active-low one-hot outputs.
module two_four_decoder (
  input  logic [1:0] sel,
  output logic [3:0] y_n
);

  // Exactly one output low, selected by sel.
  always_comb begin
    y_n      = 4'b1111;
    y_n[sel] = 1'b0;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column, samples the
// synchronised rows at the end of each column dwell, folds one full scan
// into a candidate and hands it to the debouncer.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int DWELL          = 4,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         scan_clk,
  input  logic         reset,
  keypad_scan_if.master kp
);

  localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [N_ROWS-1:0] row_s1_q, row_s2_q;
  logic [1:0]        cnt_q, cnt_d, cnt_v;
  logic [CODE_W-1:0] code_q, code_d, code_v;
  logic              sample, eos;
  cand_t             cand;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd2) ? 2'd2 : v + 2'd1;
  endfunction

  // Two-flop synchroniser; idle rows read as released.
  always_ff @(posedge scan_clk or posedge reset) begin
    if (reset) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= kp.row_n;
      row_s2_q <= row_s1_q;
    end
  end

  // Dwell counter and column index stepping; last dwell cycle is the sample.
  always_comb begin
    sample    = (dwell_q == DWELL_LAST);
    eos       = sample && (col_idx_q == COL_W'(N_COLS - 1));
    dwell_d   = sample ? '0 : dwell_q + 1'b1;
    col_idx_d = sample ? col_idx_q + 1'b1 : col_idx_q;
  end

  // Accumulate pressed keys over a scan; first key seen (column-major) is kept.
  always_comb begin
    cnt_v  = cnt_q;
    code_v = code_q;
    if (sample) begin
      for (int r = 0; r < N_ROWS; r++) begin
        if (!row_s2_q[r]) begin
          if (cnt_v == 2'd0) code_v = {ROW_W'(r), col_idx_q};
          cnt_v = sat_inc2(cnt_v);
        end
      end
    end
    cand = CAND_RESET;
    if (cnt_v == 2'd1) begin
      cand.kind = CAND_KEY;
      cand.code = code_v;
    end else if (cnt_v == 2'd2) begin
      cand.kind = CAND_MULTI;
    end
    cnt_d  = eos ? '0 : cnt_v;
    code_d = eos ? '0 : code_v;
  end

  // Scan sequencing and per-scan accumulator registers.
  always_ff @(posedge scan_clk or posedge reset) begin
    if (reset) begin
      dwell_q   <= '0;
      col_idx_q <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
    end else begin
      dwell_q   <= dwell_d;
      col_idx_q <= col_idx_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
    end
  end

  two_four_decoder u_col_dec (
    .sel (col_idx_q),
    .y_n (kp.col_n)
  );

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (scan_clk),
    .rst       (reset),
    .eos       (eos),
    .cand      (cand),
    .key_code  (kp.key_code),
    .key_valid (kp.key_valid),
    .key_down  (kp.key_down)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical keypad model drives the rows from a
// set of held keys, and a scan-level reference model predicts col_n and
// the key outputs every cycle.
module tb_keypad_scan;
  localparam int DWELL = 4;
  localparam int DEB   = 4;
  localparam int SCAN  = 4 * DWELL;

  logic        scan_clk = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] keys     = '0;   // bit index = row*4 + col

  keypad_scan_if kp ();

  keypad_scan #(.DWELL(DWELL), .DEBOUNCE_SCANS(DEB)) dut (
    .scan_clk (scan_clk),
    .reset    (reset),
    .kp       (kp.master)
  );

  always #5 scan_clk = ~scan_clk;

  // Physical keypad: a row is pulled low if a held key joins it to the driven column.
  always_comb begin
    logic [3:0] rn;
    rn = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col_n[c]) rn[r] = 1'b0;
    kp.row_n = rn;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          n;
  logic [15:0] h0, h1, h2, seen;
  int          pk, run;          // pk: 0 none, 1 key, 2 multi
  logic [3:0]  pcode;
  bit          m_pressed;
  logic        exp_valid, exp_down;
  logic [3:0]  exp_code;
  int          pulses;
  logic [3:0]  last_pulse_code;
  int          last_pulse_n;

  initial begin
    pulses = 0; last_pulse_code = '0; last_pulse_n = -1;
  end

  // Per-cycle compare against the model, then advance the model one cycle.
  always @(negedge scan_clk) begin
    if (reset) begin
      n = 0; h0 = '0; h1 = '0; h2 = '0; seen = '0;
      pk = 0; pcode = '0; run = 0; m_pressed = 0;
      exp_valid = 1'b0; exp_down = 1'b0; exp_code = '0;
    end else begin
      logic [3:0] exp_col;
      int kind, cnt, c;
      logic [3:0] code;
      bit found;
      exp_col = 4'b1111;
      exp_col[(n / DWELL) % 4] = 1'b0;
      check("col_n", 32'(kp.col_n), 32'(exp_col));
      check("key_valid", 32'(kp.key_valid), 32'(exp_valid));
      check("key_code", 32'(kp.key_code), 32'(exp_code));
      check("key_down", 32'(kp.key_down), 32'(exp_down));
      if (kp.key_valid === 1'b1) begin
        pulses++;
        last_pulse_code = kp.key_code;
        last_pulse_n    = n;
      end
      // Rows seen at a sample reflect the keypad two cycles earlier.
      h2 = h1; h1 = h0; h0 = keys;
      exp_valid = 1'b0;
      if (n % DWELL == DWELL - 1) begin
        c = (n / DWELL) % 4;
        for (int r = 0; r < 4; r++) if (h2[r*4+c]) seen[r*4+c] = 1'b1;
        if (c == 3) begin
          cnt = $countones(seen);
          found = 0; code = '0;
          for (int cc = 0; cc < 4; cc++)
            for (int rr = 0; rr < 4; rr++)
              if (!found && seen[rr*4+cc]) begin
                found = 1; code = 4'(rr*4 + cc);
              end
          kind = (cnt == 0) ? 0 : (cnt == 1) ? 1 : 2;
          if (kind != 1) code = '0;
          if (kind == pk && code == pcode) run = (run < DEB) ? run + 1 : DEB;
          else run = 1;
          pk = kind; pcode = code;
          if (!m_pressed && kind == 1 && run == DEB) begin
            m_pressed = 1; exp_valid = 1'b1; exp_code = code;
          end else if (m_pressed && kind == 0 && run == DEB) begin
            m_pressed = 0;
          end
          seen = '0;
        end
      end
      exp_down = m_pressed;
      n++;
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge scan_clk);
    #1;
  endtask

  // Asynchronous reset pulse mid-cycle with immediate output checks.
  task automatic reset_pulse(input string tag);
    @(posedge scan_clk);
    #3 reset = 1'b1;
    #1;
    check({tag, "_rst_col_n"}, 32'(kp.col_n), 32'h0E);
    check({tag, "_rst_key_code"}, 32'(kp.key_code), 32'h0);
    check({tag, "_rst_key_valid"}, 32'(kp.key_valid), 32'h0);
    check({tag, "_rst_key_down"}, 32'(kp.key_down), 32'h0);
    @(posedge scan_clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int base;
    reset = 1'b1;
    keys  = '0;
    repeat (3) @(posedge scan_clk);
    #2 reset = 1'b0;
    step(40);

    // Reset mid-scan, then column walk pinned literally
    reset_pulse("p1");
    check("p1_col0", 32'(kp.col_n), 32'h0E);
    step(4); check("p1_col1", 32'(kp.col_n), 32'h0D);
    step(4); check("p1_col2", 32'(kp.col_n), 32'h0B);
    step(4); check("p1_col3", 32'(kp.col_n), 32'h07);
    step(4); check("p1_col0b", 32'(kp.col_n), 32'h0E);
    step(48);
    check("p1_no_pulse", 32'(pulses), 32'h0);

    // Steady press of row 2 / col 1 held for well over 20 scans
    base = pulses;
    keys = 16'h0200;
    step(SCAN * 26);
    check("p2_one_pulse", 32'(pulses - base), 32'd1);
    check("p2_code", 32'(last_pulse_code), 32'd9);
    check("p2_down", 32'(kp.key_down), 32'd1);
    keys = '0;
    step(SCAN * 6);
    check("p2_released", 32'(kp.key_down), 32'd0);

    // Bounce for about 3 scans, then hold
    base = pulses;
    keys = 16'h0200;
    for (int i = 0; i < 5; i++) begin
      step(10);
      keys = keys ^ 16'h0200;
    end
    keys = 16'h0200;
    check("p3_no_pulse_bounce", 32'(pulses - base), 32'd0);
    step(SCAN * 7);
    check("p3_one_pulse", 32'(pulses - base), 32'd1);
    check("p3_code", 32'(last_pulse_code), 32'd9);
    keys = '0;
    step(SCAN * 6);

    // Two keys from idle, then one released
    base = pulses;
    keys = 16'h0021;
    step(SCAN * 6);
    check("p4_multi_no_pulse", 32'(pulses - base), 32'd0);
    keys = 16'h0020;
    step(SCAN * 6);
    check("p4_one_pulse", 32'(pulses - base), 32'd1);
    check("p4_code", 32'(last_pulse_code), 32'd5);
    keys = '0;
    step(SCAN * 6);

    // No rollover: 9 accepted, 3 added, 9 released
    base = pulses;
    keys = 16'h0200;
    step(SCAN * 6);
    check("p5_accept", 32'(pulses - base), 32'd1);
    keys = 16'h0208;
    step(SCAN * 6);
    keys = 16'h0008;
    step(SCAN * 6);
    check("p5_no_new_event", 32'(pulses - base), 32'd1);
    check("p5_still_down", 32'(kp.key_down), 32'd1);
    keys = '0;
    step(SCAN * 6);
    check("p5_up", 32'(kp.key_down), 32'd0);
    check("p5_code_kept", 32'(kp.key_code), 32'd9);

    // Reset while held: fresh acceptance 4 scans later
    keys = 16'h0200;
    step(SCAN * 6);
    check("p6_down_before", 32'(kp.key_down), 32'd1);
    reset_pulse("p6");
    base = pulses;
    step(100);
    check("p6_one_pulse", 32'(pulses - base), 32'd1);
    check("p6_code", 32'(last_pulse_code), 32'd9);
    check("p6_pulse_cycle", 32'(last_pulse_n), 32'd64);
    keys = '0;
    step(SCAN * 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
